// File: rtl/maze_pkg.sv
// Shared state, direction encoding and offset helpers for the DFS maze solver.
// Build option: define MAZE_DIAG_EN for 8-neighbour search (default is 4-neighbour).
package maze_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMark,
        StTry,
        StWait,
        StPop,
        StStream,
        StDone,
        StFail
    } state_e;

    localparam logic [2:0] DirUp        = 3'd0;
    localparam logic [2:0] DirRight     = 3'd1;
    localparam logic [2:0] DirDown      = 3'd2;
    localparam logic [2:0] DirLeft      = 3'd3;
    localparam logic [2:0] DirUpRight   = 3'd4;
    localparam logic [2:0] DirDownRight = 3'd5;
    localparam logic [2:0] DirDownLeft  = 3'd6;
    localparam logic [2:0] DirUpLeft    = 3'd7;

`ifdef MAZE_DIAG_EN
    localparam int unsigned NumDirs = 8;
    localparam int unsigned DirW    = 3;
`else
    localparam int unsigned NumDirs = 4;
    localparam int unsigned DirW    = 2;
`endif
    // Extra top bit lets the counter reach NumDirs, which marks the cell as exhausted.
    localparam int unsigned DirCntW = DirW + 1;

    // Offsets are 2-bit two's complement: 2'b01 = +1, 2'b11 = -1, 2'b00 = none.
    function automatic logic [1:0] dir_dx(input logic [2:0] dir);
        case (dir)
            DirUp:        dir_dx = 2'b00;
            DirRight:     dir_dx = 2'b01;
            DirDown:      dir_dx = 2'b00;
            DirLeft:      dir_dx = 2'b11;
            DirUpRight:   dir_dx = 2'b01;
            DirDownRight: dir_dx = 2'b01;
            DirDownLeft:  dir_dx = 2'b11;
            DirUpLeft:    dir_dx = 2'b11;
            default:      dir_dx = 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] dir_dy(input logic [2:0] dir);
        case (dir)
            DirUp:        dir_dy = 2'b11;
            DirRight:     dir_dy = 2'b00;
            DirDown:      dir_dy = 2'b01;
            DirLeft:      dir_dy = 2'b00;
            DirUpRight:   dir_dy = 2'b11;
            DirDownRight: dir_dy = 2'b01;
            DirDownLeft:  dir_dy = 2'b01;
            DirUpLeft:    dir_dy = 2'b11;
            default:      dir_dy = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/maze_path_stack.sv
// LIFO of {x, y, next-dir} path entries with top-entry update and an indexed read port.
module maze_path_stack #(
    parameter int unsigned X_W         = 4,
    parameter int unsigned Y_W         = 4,
    parameter int unsigned D_W         = 3,
    parameter int unsigned STACK_DEPTH = 256,
    parameter int unsigned SP_W        = $clog2(STACK_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            push,
    input  logic [X_W-1:0]  push_x,
    input  logic [Y_W-1:0]  push_y,
    input  logic [D_W-1:0]  push_dir,
    input  logic            pop,
    input  logic            upd,
    input  logic [D_W-1:0]  upd_dir,
    input  logic [SP_W-1:0] rd_idx,
    output logic [X_W-1:0]  rd_x,
    output logic [Y_W-1:0]  rd_y,
    output logic [D_W-1:0]  rd_dir,
    output logic [SP_W-1:0] sp,
    output logic            full,
    output logic            empty
);

    localparam int unsigned AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [X_W-1:0] x_mem   [STACK_DEPTH];
    logic [Y_W-1:0] y_mem   [STACK_DEPTH];
    logic [D_W-1:0] dir_mem [STACK_DEPTH];

    logic [SP_W-1:0] sp_q;
    logic [SP_W-1:0] top_idx;

    assign top_idx = sp_q - SP_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
        end else if (clear) begin
            sp_q <= '0;
        end else if (push) begin
            sp_q <= sp_q + SP_W'(1);
        end else if (pop) begin
            sp_q <= top_idx;
        end
    end

    // Entry storage needs no reset: only slots below sp are ever read meaningfully.
    always_ff @(posedge clk) begin
        if (push) begin
            x_mem[sp_q[AW-1:0]]   <= push_x;
            y_mem[sp_q[AW-1:0]]   <= push_y;
            dir_mem[sp_q[AW-1:0]] <= push_dir;
        end else if (upd) begin
            dir_mem[top_idx[AW-1:0]] <= upd_dir;
        end
    end

    assign rd_x   = x_mem[rd_idx[AW-1:0]];
    assign rd_y   = y_mem[rd_idx[AW-1:0]];
    assign rd_dir = dir_mem[rd_idx[AW-1:0]];
    assign sp     = sp_q;
    assign full   = (sp_q == SP_W'(STACK_DEPTH));
    assign empty  = (sp_q == '0);

    logic unused_idx_msbs;
    assign unused_idx_msbs = ^{rd_idx[SP_W-1:AW], top_idx[SP_W-1:AW], sp_q[SP_W-1:AW]};

endmodule

// File: rtl/maze_dfs_solver.sv
// Depth-first maze solver: walks a bit-map maze in external RAM, marks visited cells and
// streams the src->dst path. Build option MAZE_DIAG_EN (see maze_pkg) enables diagonals.
module maze_dfs_solver
    import maze_pkg::*;
#(
    parameter int unsigned X_W         = 4,
    parameter int unsigned Y_W         = 4,
    parameter int unsigned STACK_DEPTH = 256,
    parameter int unsigned MEM_LAT     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [X_W-1:0]               src_x,
    input  logic [Y_W-1:0]               src_y,
    input  logic [X_W-1:0]               dst_x,
    input  logic [Y_W-1:0]               dst_y,
    output logic [X_W+Y_W-1:0]           mem_addr,
    output logic                         mem_rd,
    output logic                         mem_wr,
    input  logic                         mem_rdata,
    output logic                         path_valid,
    input  logic                         path_ready,
    output logic [X_W-1:0]               path_x,
    output logic [Y_W-1:0]               path_y,
    output logic                         path_last,
    output logic [$clog2(STACK_DEPTH):0] path_len,
    output logic                         busy,
    output logic                         done,
    output logic                         fail,
    output logic                         overflow
);

    localparam int unsigned SP_W  = $clog2(STACK_DEPTH) + 1;
    localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_e state_q, state_d;

    logic [X_W-1:0]     cur_x_q, cur_x_d, dst_x_q, dst_x_d;
    logic [Y_W-1:0]     cur_y_q, cur_y_d, dst_y_q, dst_y_d;
    logic [DirCntW-1:0] dir_q, dir_d;
    logic [LAT_W-1:0]   wait_q, wait_d;
    logic [SP_W-1:0]    idx_q, idx_d;
    logic               ovf_q, ovf_d;

    logic               stk_clear, stk_push, stk_pop, stk_upd;
    logic [SP_W-1:0]    stk_rd_idx, stk_sp;
    logic [X_W-1:0]     stk_rd_x;
    logic [Y_W-1:0]     stk_rd_y;
    logic [DirCntW-1:0] stk_rd_dir;
    logic               stk_full, stk_empty;

    maze_path_stack #(
        .X_W         (X_W),
        .Y_W         (Y_W),
        .D_W         (DirCntW),
        .STACK_DEPTH (STACK_DEPTH),
        .SP_W        (SP_W)
    ) u_stack (
        .clk      (clk),
        .rst      (rst),
        .clear    (stk_clear),
        .push     (stk_push),
        .push_x   (cur_x_q),
        .push_y   (cur_y_q),
        .push_dir ('0),
        .pop      (stk_pop),
        .upd      (stk_upd),
        .upd_dir  (dir_q + DirCntW'(1)),
        .rd_idx   (stk_rd_idx),
        .rd_x     (stk_rd_x),
        .rd_y     (stk_rd_y),
        .rd_dir   (stk_rd_dir),
        .sp       (stk_sp),
        .full     (stk_full),
        .empty    (stk_empty)
    );

    // Neighbour of the current cell in the current direction, plus a grid-bounds check.
    logic [2:0]     dir3;
    logic [1:0]     dx, dy;
    logic [X_W-1:0] nb_x;
    logic [Y_W-1:0] nb_y;
    logic           nb_ok, dir_exh, at_dst, last_idx;

    assign dir3    = 3'(dir_q[DirW-1:0]);
    assign dx      = dir_dx(dir3);
    assign dy      = dir_dy(dir3);
    assign nb_x    = cur_x_q + X_W'($signed(dx));
    assign nb_y    = cur_y_q + Y_W'($signed(dy));
    assign nb_ok   = !((dx == 2'b01) && (cur_x_q == '1)) && !((dx == 2'b11) && (cur_x_q == '0))
                  && !((dy == 2'b01) && (cur_y_q == '1)) && !((dy == 2'b11) && (cur_y_q == '0));
    assign dir_exh  = (dir_q == DirCntW'(NumDirs));
    assign at_dst   = (cur_x_q == dst_x_q) && (cur_y_q == dst_y_q);
    assign last_idx = (idx_q == stk_sp - SP_W'(1));

    always_comb begin
        state_d    = state_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        dst_x_d    = dst_x_q;
        dst_y_d    = dst_y_q;
        dir_d      = dir_q;
        wait_d     = wait_q;
        idx_d      = idx_q;
        ovf_d      = ovf_q;
        stk_clear  = 1'b0;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        stk_upd    = 1'b0;
        stk_rd_idx = idx_q;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;

        unique case (state_q)
            StIdle, StDone, StFail: begin
                if (start) begin
                    cur_x_d   = src_x;
                    cur_y_d   = src_y;
                    dst_x_d   = dst_x;
                    dst_y_d   = dst_y;
                    dir_d     = '0;
                    ovf_d     = 1'b0;
                    stk_clear = 1'b1;
                    state_d   = StMark;
                end
            end
            StMark: begin
                mem_wr   = 1'b1;
                mem_addr = {cur_y_q, cur_x_q};
                if (stk_full) begin
                    ovf_d   = 1'b1;
                    state_d = StFail;
                end else begin
                    stk_push = 1'b1;
                    dir_d    = '0;
                    idx_d    = '0;
                    state_d  = at_dst ? StStream : StTry;
                end
            end
            StTry: begin
                if (dir_exh) begin
                    state_d = StPop;
                end else if (!nb_ok) begin
                    dir_d = dir_q + DirCntW'(1);
                end else begin
                    mem_rd   = 1'b1;
                    mem_addr = {nb_y, nb_x};
                    wait_d   = '0;
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (wait_q == LAT_W'(MEM_LAT - 1)) begin
                    if (!mem_rdata) begin
                        // Parent resumes after this direction once the child is popped.
                        stk_upd = 1'b1;
                        cur_x_d = nb_x;
                        cur_y_d = nb_y;
                        dir_d   = '0;
                        state_d = StMark;
                    end else begin
                        dir_d   = dir_q + DirCntW'(1);
                        state_d = StTry;
                    end
                end else begin
                    wait_d = wait_q + LAT_W'(1);
                end
            end
            StPop: begin
                stk_pop    = 1'b1;
                stk_rd_idx = stk_sp - SP_W'(2);
                if (stk_sp == SP_W'(1)) begin
                    state_d = StFail;
                end else begin
                    cur_x_d = stk_rd_x;
                    cur_y_d = stk_rd_y;
                    dir_d   = stk_rd_dir;
                    state_d = StTry;
                end
            end
            StStream: begin
                if (path_ready) begin
                    if (last_idx) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + SP_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cur_x_q <= '0;
            cur_y_q <= '0;
            dst_x_q <= '0;
            dst_y_q <= '0;
            dir_q   <= '0;
            wait_q  <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            dst_x_q <= dst_x_d;
            dst_y_q <= dst_y_d;
            dir_q   <= dir_d;
            wait_q  <= wait_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StStream) || (state_q == StDone);
    assign fail       = (state_q == StFail);
    assign overflow   = ovf_q;
    assign path_valid = (state_q == StStream);
    assign path_x     = path_valid ? stk_rd_x : '0;
    assign path_y     = path_valid ? stk_rd_y : '0;
    assign path_last  = path_valid && last_idx;
    assign path_len   = done ? stk_sp : '0;

    logic unused_empty;
    assign unused_empty = stk_empty;

endmodule

// File: tb/tb_maze_dfs_solver.sv
// Bench for maze_dfs_solver: directed vector table, reset/overflow sequences and random
// mazes checked against a queue-based DFS reference model.
module tb_maze_dfs_solver;

    localparam int unsigned MAIN_DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic [1:0] src_x, src_y, dst_x, dst_y;
    logic [3:0] mem_addr;
    logic       mem_rd, mem_wr, mem_rdata;
    logic       path_valid, path_ready, path_last;
    logic [1:0] path_x, path_y;
    logic [3:0] path_len;
    logic       busy, done, fail, overflow;

    logic       b_start;
    logic [1:0] b_src_x, b_src_y, b_dst_x, b_dst_y;
    logic [3:0] b_mem_addr;
    logic       b_mem_rd, b_mem_wr;
    logic       b_path_valid, b_path_last;
    logic [1:0] b_path_x, b_path_y;
    logic [1:0] b_path_len;
    logic       b_busy, b_done, b_fail, b_overflow;

    maze_dfs_solver #(.X_W(2), .Y_W(2), .STACK_DEPTH(MAIN_DEPTH), .MEM_LAT(2)) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_x(src_x), .src_y(src_y), .dst_x(dst_x), .dst_y(dst_y),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
        .path_valid(path_valid), .path_ready(path_ready), .path_x(path_x), .path_y(path_y),
        .path_last(path_last), .path_len(path_len),
        .busy(busy), .done(done), .fail(fail), .overflow(overflow)
    );

    // Small-stack instance over an all-free maze, for the overflow path.
    maze_dfs_solver #(.X_W(2), .Y_W(2), .STACK_DEPTH(2), .MEM_LAT(1)) dut_small (
        .clk(clk), .rst(rst), .start(b_start),
        .src_x(b_src_x), .src_y(b_src_y), .dst_x(b_dst_x), .dst_y(b_dst_y),
        .mem_addr(b_mem_addr), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_rdata(1'b0),
        .path_valid(b_path_valid), .path_ready(1'b1), .path_x(b_path_x), .path_y(b_path_y),
        .path_last(b_path_last), .path_len(b_path_len),
        .busy(b_busy), .done(b_done), .fail(b_fail), .overflow(b_overflow)
    );

    // Maze RAM with a two-cycle read pipeline, plus access counters.
    logic [15:0] mem;
    logic [15:0] load_val;
    logic        load_req = 1'b0;
    logic [1:0]  rd_pipe;
    int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;

    always @(posedge clk) begin
        if (load_req) mem <= load_val;
        else if (mem_wr) mem[mem_addr] <= 1'b1;
        rd_pipe <= {rd_pipe[0], mem[mem_addr]};
        if (mem_rd) rd_cnt <= rd_cnt + 1;
        if (mem_wr) wr_cnt <= wr_cnt + 1;
        if (mem_rd && mem_wr) both_cnt <= both_cnt + 1;
    end
    assign mem_rdata = rd_pipe[1];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected results for the current run.
    int          exp_q[$];
    bit          m_fail, m_ovf;
    int          m_reads, m_writes;
    logic [15:0] m_mem;

    // Reference DFS over a 4x4 grid: cell index = y*4 + x.
    task automatic model(input logic [15:0] maze, input int sx, input int sy, input int tx,
                         input int ty, input int depth);
        int mdx[4] = '{0, 1, 0, -1};
        int mdy[4] = '{-1, 0, 1, 0};
        logic [15:0] vis;
        int st[$];
        int dr[$];
        int cur, d, nx, ny, n, tgt;
        bit fin;
        vis = maze;
        m_fail = 0; m_ovf = 0; m_reads = 0; m_writes = 0;
        tgt = ty * 4 + tx;
        cur = sy * 4 + sx;
        vis[cur] = 1'b1;
        m_writes++;
        st.push_back(cur);
        dr.push_back(0);
        fin = (cur == tgt);
        while (!fin) begin
            cur = st[st.size()-1];
            d = dr[dr.size()-1];
            if (d == 4) begin
                void'(st.pop_back());
                void'(dr.pop_back());
                if (st.size() == 0) begin m_fail = 1; fin = 1; end
            end else begin
                dr[dr.size()-1] = d + 1;
                nx = cur % 4 + mdx[d];
                ny = cur / 4 + mdy[d];
                if (nx >= 0 && nx < 4 && ny >= 0 && ny < 4) begin
                    m_reads++;
                    n = ny * 4 + nx;
                    if (!vis[n]) begin
                        vis[n] = 1'b1;
                        m_writes++;
                        if (st.size() == depth) begin
                            m_fail = 1; m_ovf = 1; fin = 1;
                        end else begin
                            st.push_back(n);
                            dr.push_back(0);
                            fin = (n == tgt);
                        end
                    end
                end
            end
        end
        exp_q.delete();
        if (!m_fail) foreach (st[i]) exp_q.push_back(st[i]);
        m_mem = vis;
    endtask

    // Launch one solve on the main DUT and check it against exp_q / m_*.
    // rmode: 0 always ready, 1 ready pattern 1-0-0-1, 2 random ready.
    task automatic run_main(input logic [15:0] maze, input int sx, input int sy, input int tx,
                            input int ty, input int rmode);
        int rd0, wr0, beats, cyc, scyc;
        bit fin;
        @(negedge clk);
        load_val = maze;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        src_x = 2'(sx); src_y = 2'(sy); dst_x = 2'(tx); dst_y = 2'(ty);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_launch", 32'(busy), 1);
        beats = 0; cyc = 0; scyc = 0; fin = 0;
        while (!fin) begin
            case (rmode)
                0:       path_ready = 1'b1;
                1:       path_ready = (scyc % 4 == 0) || (scyc % 4 == 3);
                default: path_ready = 1'($urandom_range(0, 1));
            endcase
            if (path_valid) begin
                if (beats < exp_q.size()) begin
                    check("beat_xy", 32'({path_y, path_x}), 32'(exp_q[beats]));
                    check("beat_last", 32'(path_last), 32'(beats == exp_q.size() - 1));
                end
                if (path_ready) beats++;
                scyc++;
            end
            if (fail || (done && !path_valid)) begin
                fin = 1;
            end else begin
                cyc++;
                if (cyc > 3000) begin
                    checks++;
                    errors++;
                    $display("FAIL timeout: got no finish after %0d cycles", cyc);
                    fin = 1;
                end
                @(negedge clk);
            end
        end
        path_ready = 1'b0;
        check("fail_flag", 32'(fail), 32'(m_fail));
        check("done_flag", 32'(done), 32'(!m_fail));
        check("overflow_flag", 32'(overflow), 32'(m_ovf));
        check("beats_accepted", 32'(beats), 32'(exp_q.size()));
        if (!m_fail) check("path_len", 32'(path_len), 32'(exp_q.size()));
        check("mem_reads", 32'(rd_cnt - rd0), 32'(m_reads));
        check("mem_writes", 32'(wr_cnt - wr0), 32'(m_writes));
        check("mem_marks", 32'(mem), 32'(m_mem));
        check("rd_wr_overlap", 32'(both_cnt), 0);
    endtask

    typedef struct {
        logic [15:0]     maze;
        int              sx, sy, tx, ty;
        int              len;
        bit              f, ovf;
        int              reads, writes;
        logic [15:0]     mem_after;
        logic [3:0][3:0] path;
        int              rmode;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input int i);
        exp_q.delete();
        for (int k = 0; k < vecs[i].len; k++) exp_q.push_back(int'(vecs[i].path[k]));
        m_fail   = vecs[i].f;
        m_ovf    = vecs[i].ovf;
        m_reads  = vecs[i].reads;
        m_writes = vecs[i].writes;
        m_mem    = vecs[i].mem_after;
        run_main(vecs[i].maze, vecs[i].sx, vecs[i].sy, vecs[i].tx, vecs[i].ty, vecs[i].rmode);
    endtask

    initial begin
        // Empty corridor run, walled-in src, dead-end backtrack, stalled stream, src==dst.
        vecs[0] = '{16'h0000, 0, 0, 3, 0, 4, 1'b0, 1'b0, 3, 4, 16'h000F,
                    {4'd3, 4'd2, 4'd1, 4'd0}, 0};
        vecs[1] = '{16'h0252, 1, 1, 3, 3, 0, 1'b1, 1'b0, 4, 1, 16'h0272,
                    {4'd0, 4'd0, 4'd0, 4'd0}, 0};
        vecs[2] = '{16'h0268, 0, 0, 0, 3, 4, 1'b0, 1'b0, 14, 6, 16'h137F,
                    {4'd12, 4'd8, 4'd4, 4'd0}, 0};
        vecs[3] = '{16'h0000, 0, 0, 3, 0, 4, 1'b0, 1'b0, 3, 4, 16'h000F,
                    {4'd3, 4'd2, 4'd1, 4'd0}, 1};
        vecs[4] = '{16'h0000, 2, 2, 2, 2, 1, 1'b0, 1'b0, 0, 1, 16'h0400,
                    {4'd0, 4'd0, 4'd0, 4'd10}, 2};

        rst = 1'b1;
        start = 1'b0; b_start = 1'b0; path_ready = 1'b0;
        src_x = '0; src_y = '0; dst_x = '0; dst_y = '0;
        b_src_x = '0; b_src_y = '0; b_dst_x = '0; b_dst_y = '0;
        load_val = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({busy, done, fail, overflow, path_valid, path_last, mem_rd,
                                    mem_wr, mem_addr, path_x, path_y, path_len}), 0);
        check("reset_outputs_small", 32'({b_busy, b_done, b_fail, b_overflow, b_path_valid,
                                          b_mem_rd, b_mem_wr, b_path_len}), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) run_vec(i);

        // Abort in WAIT via reset, then relaunch with src==dst.
        begin
            int cyc;
            @(negedge clk);
            load_val = 16'h0268;
            load_req = 1'b1;
            @(negedge clk);
            load_req = 1'b0;
            src_x = 2'd0; src_y = 2'd0; dst_x = 2'd0; dst_y = 2'd3;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc = 0;
            while (!mem_rd && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
            check("reached_read", 32'(mem_rd), 1);
            @(posedge clk);
            #2;
            rst = 1'b1;
            #1;
            check("reset_in_wait", 32'({busy, done, fail, overflow, path_valid, path_last,
                                        mem_rd, mem_wr, mem_addr, path_x, path_y, path_len}), 0);
            @(negedge clk);
            rst = 1'b0;
        end
        run_vec(4);

        // Stack of two cannot hold a path three cells long.
        begin
            int cyc, bvalid;
            @(negedge clk);
            b_src_x = 2'd0; b_src_y = 2'd0; b_dst_x = 2'd3; b_dst_y = 2'd0;
            b_start = 1'b1;
            @(negedge clk);
            b_start = 1'b0;
            cyc = 0; bvalid = 0;
            while (!(b_fail || b_done) && cyc < 200) begin
                if (b_path_valid) bvalid++;
                @(negedge clk);
                cyc++;
            end
            check("ovf_fail", 32'(b_fail), 1);
            check("ovf_flag", 32'(b_overflow), 1);
            check("ovf_no_beats", 32'(bvalid), 0);
            b_src_x = 2'd1; b_src_y = 2'd1; b_dst_x = 2'd1; b_dst_y = 2'd1;
            b_start = 1'b1;
            @(negedge clk);
            b_start = 1'b0;
            check("relaunch_clears_flags", 32'({b_fail, b_overflow}), 0);
            cyc = 0;
            while (!(b_done && !b_path_valid) && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            check("small_single_len", 32'(b_path_len), 1);
        end

        for (int t = 0; t < 40; t++) begin
            logic [15:0] maze;
            int sx, sy, tx, ty;
            maze = 16'($urandom() & $urandom());
            sx = $urandom_range(0, 3); sy = $urandom_range(0, 3);
            tx = $urandom_range(0, 3); ty = $urandom_range(0, 3);
            model(maze, sx, sy, tx, ty, MAIN_DEPTH);
            run_main(maze, sx, sy, tx, ty, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
